// File: rtl/SGPkg.sv
// Shared defaults, per-generator state word and scheduler FSM encoding
// for the spike generator scheduler.
package SGPkg;

    localparam int NGENS_DEF   = 8;
    localparam int NPERIOD_DEF = 16;
    localparam int NTAG_DEF    = 11;
    localparam int NCT_DEF     = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_UPDATE,
        ST_EMIT
    } sg_state_e;

    // Default-width layout of one RAM word (period in the MSBs, tag in the LSBs).
    typedef struct packed {
        logic [NPERIOD_DEF-1:0] period;
        logic [NPERIOD_DEF-1:0] ticks;
        logic [NTAG_DEF-1:0]    tag;
    } gen_state_t;

endpackage

// File: rtl/sg_state_ram.sv
// Simple dual-port generator state RAM: one write port, one registered read port.
// Contents are intentionally not reset so programming survives a scheduler reset.
module sg_state_ram #(
    parameter int AW = 8,
    parameter int DW = 43
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rd_data_q <= mem_q[raddr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/spike_gen_scheduler.sv
// Scans generator state once per time unit, decrements tick counters and
// emits the tag of every generator whose counter expires.
module spike_gen_scheduler
    import SGPkg::*;
#(
    parameter int Ngens   = NGENS_DEF,
    parameter int Nperiod = NPERIOD_DEF,
    parameter int Ntag    = NTAG_DEF,
    parameter int Nct     = NCT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                time_unit_pulse,
    input  logic [Ngens-1:0]    gens_used,
    input  logic [2**Ngens-1:0] gens_en,
    input  logic [Ngens-1:0]    prog_gen_idx,
    input  logic [Nperiod-1:0]  prog_period,
    input  logic [Nperiod-1:0]  prog_ticks,
    input  logic [Ntag-1:0]     prog_tag,
    input  logic                prog_v,
    output logic                prog_a,
    output logic [Ntag-1:0]     out_tag,
    output logic [Nct-1:0]      out_ct,
    output logic                out_v,
    input  logic                out_a,
    output logic                missed_unit
);

    typedef struct packed {
        logic [Nperiod-1:0] period;
        logic [Nperiod-1:0] ticks;
        logic [Ntag-1:0]    tag;
    } word_t;

    localparam int WordW = 2 * Nperiod + Ntag;

    sg_state_e        state_q, state_d;
    logic [Ngens-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             missed_q, missed_d;
    logic             out_v_q, out_v_d;
    logic [Ntag-1:0]  out_tag_q, out_tag_d;
    logic [Nct-1:0]   out_ct_q, out_ct_d;

    logic             ram_we, ram_re;
    logic [Ngens-1:0] ram_waddr;
    word_t            ram_wdata, rd;
    logic [WordW-1:0] rd_raw;
    logic             scan_go, active, last_gen;

    sg_state_ram #(.AW(Ngens), .DW(WordW)) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .re     (ram_re),
        .raddr  (idx_q),
        .rd_data(rd_raw)
    );

    assign rd       = rd_raw;
    assign scan_go  = (state_q == ST_IDLE) && (time_unit_pulse || pend_q);
    assign active   = gens_en[idx_q] && (rd.period != '0);
    assign last_gen = (idx_q == gens_used);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        missed_d  = missed_q;
        out_v_d   = out_v_q;
        out_tag_d = out_tag_q;
        out_ct_d  = out_ct_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = idx_q;
        ram_wdata = rd;
        prog_a    = 1'b0;

        // Only one time unit may queue behind a running scan; further ones are lost.
        if (time_unit_pulse && state_q != ST_IDLE) begin
            if (pend_q) missed_d = 1'b1;
            else        pend_d   = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (scan_go) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                    pend_d  = time_unit_pulse && pend_q;
                end else if (prog_v && !reset) begin
                    prog_a    = 1'b1;
                    ram_we    = 1'b1;
                    ram_waddr = prog_gen_idx;
                    ram_wdata = {prog_period, prog_ticks, prog_tag};
                end
            end
            ST_READ: begin
                ram_re  = 1'b1;
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (active && rd.ticks == '0) begin
                    ram_we          = 1'b1;
                    ram_wdata.ticks = rd.period - 1'b1;
                    out_v_d         = 1'b1;
                    out_tag_d       = rd.tag;
                    out_ct_d        = Nct'(1);
                    state_d         = ST_EMIT;
                end else begin
                    if (active) begin
                        ram_we          = 1'b1;
                        ram_wdata.ticks = rd.ticks - 1'b1;
                    end
                    state_d = last_gen ? ST_IDLE : ST_READ;
                    idx_d   = last_gen ? '0 : idx_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_a) begin
                    out_v_d = 1'b0;
                    state_d = last_gen ? ST_IDLE : ST_READ;
                    idx_d   = last_gen ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            missed_q  <= 1'b0;
            out_v_q   <= 1'b0;
            out_tag_q <= '0;
            out_ct_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            missed_q  <= missed_d;
            out_v_q   <= out_v_d;
            out_tag_q <= out_tag_d;
            out_ct_q  <= out_ct_d;
        end
    end

    assign out_v       = out_v_q;
    assign out_tag     = out_tag_q;
    assign out_ct      = out_ct_q;
    assign missed_unit = missed_q;

endmodule
